// File: rtl/msg_display_queue.sv
// rtl/msg_display_queue.sv - PID-tagged message FIFO with timed display; `MSG_QUEUE_ACK_EN enables early Ack dismiss
module msg_display_queue #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [4:0]               MSG_In,
  input  logic                     MSG_Sign,
  input  logic [4:0]               PID_In,
  input  logic                     Ack,
  output logic [4:0]               Msg_Code,
  output logic [4:0]               Msg_PID,
  output logic                     Msg_Valid,
  output logic [$clog2(DEPTH):0]   Queue_Count,
  output logic                     Queue_Full,
  output logic                     Overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = $clog2(HOLD_CYCLES);

  typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

  state_t          state, next_state;
  logic            sign_q, push_q;
  logic [9:0]      data_q;
  logic [9:0]      mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [HW-1:0]   hold;
  logic            ack_hit, pop, load, full, push_acc, drop;

`ifdef MSG_QUEUE_ACK_EN
  assign ack_hit = Ack;
`else
  logic ack_unused;
  assign ack_unused = Ack;
  assign ack_hit    = 1'b0;
`endif

  assign full        = (count == CW'(DEPTH));
  // A push on the pop cycle reuses the slot being freed, so it is never dropped.
  assign push_acc    = push_q && (!full || pop);
  assign drop        = push_q && full && !pop;
  assign Queue_Count = count;
  assign Queue_Full  = full;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    load       = 1'b0;
    Msg_Valid  = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          next_state = SHOW;
          load       = 1'b1;
        end
      end
      SHOW: begin
        Msg_Valid = 1'b1;
        if (hold == '0 || ack_hit) begin
          next_state = GAP;
          pop        = 1'b1;
        end
      end
      GAP: begin
        if (count != '0) begin
          next_state = SHOW;
          load       = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Edge capture is registered with its data, so the FIFO write lands one edge after the rising edge.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sign_q   <= 1'b0;
      push_q   <= 1'b0;
      data_q   <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hold     <= '0;
      Msg_Code <= '0;
      Msg_PID  <= '0;
      Overflow <= 1'b0;
    end else begin
      sign_q <= MSG_Sign;
      push_q <= MSG_Sign && !sign_q && (MSG_In != 5'd0);
      data_q <= {PID_In, MSG_In};
      if (push_acc) begin
        mem[wr_ptr] <= data_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_acc) - CW'(pop);
      if (drop) Overflow <= 1'b1;
      if (load) begin
        hold                <= HW'(HOLD_CYCLES - 1);
        {Msg_PID, Msg_Code} <= mem[rd_ptr];
      end else if (state == SHOW && hold != '0) begin
        hold <= hold - 1'b1;
      end
    end
  end

endmodule
